// File: rtl/ssd_pkg.sv
// Shared types and helpers for the seven-segment display controller.
package ssd_pkg;

    localparam int         BCD_DIGITS = 5;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_t;

    // Display register: one nibble per digit plus a per-digit blank flag.
    typedef struct packed {
        logic [7:0]      blank;
        logic [7:0][3:0] nib;
    } disp_t;

    // Hex digit to {a,b,c,d,e,f,g}, active-low.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    function automatic disp_t hex_disp(input logic [15:0] v);
        disp_t d;
        d.nib   = {16'h0000, v};
        d.blank = 8'hF0;
        return d;
    endfunction

    function automatic disp_t dec_disp(input logic [4*BCD_DIGITS-1:0] bcd);
        disp_t d;
        d.nib   = {12'h000, bcd};
        d.blank = 8'hE0;
        return d;
    endfunction

endpackage

// File: rtl/ssd_display_ctrl_if.sv
// Game-side request/status bundle and the pin-level display outputs.
interface ssd_display_ctrl_if;
    logic [15:0] value_in;
    logic        load;
    logic        dec_mode;
    logic        blank_lz;
    logic [7:0]  dp_mask;
    logic        busy;
    logic [7:0]  An;
    logic [7:0]  Seg;

    modport master (output value_in, load, dec_mode, blank_lz, dp_mask,
                    input  busy, An, Seg);
    modport slave  (input  value_in, load, dec_mode, blank_lz, dp_mask,
                    output busy, An, Seg);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 16 shift cycles after start, then a one-cycle done pulse with bcd valid.
// last flags the final shift cycle so the owner can leave SHIFT in step with the datapath.
module bin2bcd_seq
    import ssd_pkg::*;
(
    input  logic                    ClkPort,
    input  logic                    Reset,
    input  logic                    start,
    input  logic [15:0]             bin_in,
    output logic                    last,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);
    logic [15:0]             bin_q;
    logic [4*BCD_DIGITS-1:0] bcd_q;
    logic [4*BCD_DIGITS-1:0] bcd_adj;
    logic [3:0]              iter;
    logic                    run;

    always_comb begin
        bcd_adj = bcd_q;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
        end
    end

    assign last = run && (iter == 4'd15);
    assign bcd  = bcd_q;

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            bin_q <= '0;
            bcd_q <= '0;
            iter  <= '0;
            run   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                bin_q <= bin_in;
                bcd_q <= '0;
                iter  <= '0;
                run   <= 1'b1;
            end else if (run) begin
                {bcd_q, bin_q} <= {bcd_adj[4*BCD_DIGITS-2:0], bin_q, 1'b0};
                iter           <= iter + 4'd1;
                if (iter == 4'd15) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ssd_display_ctrl.sv
// Seven-segment owner: hex loads land on the load edge, decimal loads after a 17-cycle conversion.
// Loads while busy park in a one-deep pending slot (last wins); anodes are scanned one slot per SCAN_DIV cycles.
module ssd_display_ctrl
    import ssd_pkg::*;
#(
    parameter int SCAN_DIV   = 262144,
    parameter int NUM_DIGITS = 8
) (
    input  logic              ClkPort,
    input  logic              Reset,
    ssd_display_ctrl_if.slave bus
);
    localparam int               PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

    conv_state_t             state;
    disp_t                   disp;
    logic                    busy_q;
    logic                    pend_vld, pend_dec;
    logic [15:0]             pend_val;
    logic                    req_vld, req_dec;
    logic [15:0]             req_val;
    logic                    cvt_start, cvt_last, cvt_done;
    logic [4*BCD_DIGITS-1:0] cvt_bcd;
    logic [PRE_W-1:0]        pre;
    logic [2:0]              idx;
    logic [7:0]              an_q, seg_q, an_nxt, seg_nxt;
    logic [31:0]             nib_flat;
    logic [3:0]              dig_nib;
    logic                    lz_hit, dig_blank;

    // A live load always takes priority over what is parked in the pending slot.
    assign req_vld   = bus.load | pend_vld;
    assign req_dec   = bus.load ? bus.dec_mode : pend_dec;
    assign req_val   = bus.load ? bus.value_in : pend_val;
    assign cvt_start = req_vld && req_dec && ((state == IDLE) || (state == COMMIT));

    bin2bcd_seq u_bcd (
        .ClkPort (ClkPort),
        .Reset   (Reset),
        .start   (cvt_start),
        .bin_in  (req_val),
        .last    (cvt_last),
        .done    (cvt_done),
        .bcd     (cvt_bcd)
    );

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            pend_vld <= 1'b0;
            pend_dec <= 1'b0;
            pend_val <= '0;
            disp     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_vld) begin
                        pend_vld <= 1'b0;
                        if (req_dec) begin
                            state  <= SHIFT;
                            busy_q <= 1'b1;
                        end else begin
                            disp <= hex_disp(req_val);
                        end
                    end
                end
                SHIFT: begin
                    if (bus.load) begin
                        pend_vld <= 1'b1;
                        pend_dec <= bus.dec_mode;
                        pend_val <= bus.value_in;
                    end
                    if (cvt_last) state <= COMMIT;
                end
                COMMIT: begin
                    if (cvt_done) disp <= dec_disp(cvt_bcd);
                    if (cvt_start) begin
                        state    <= SHIFT;
                        pend_vld <= 1'b0;
                    end else begin
                        // A hex request waiting here is applied from IDLE on the next edge.
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        if (bus.load) begin
                            pend_vld <= 1'b1;
                            pend_dec <= bus.dec_mode;
                            pend_val <= bus.value_in;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign nib_flat  = disp.nib;
    assign dig_nib   = disp.nib[idx];
    assign lz_hit    = bus.blank_lz && (idx != 3'd0) && ((nib_flat >> {idx, 2'b00}) == 32'd0);
    assign dig_blank = disp.blank[idx] | lz_hit;
    assign seg_nxt   = dig_blank ? SEG_BLANK : {seg_decode(dig_nib), ~bus.dp_mask[idx]};
    assign an_nxt    = ~(8'b0000_0001 << idx);

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            pre   <= '0;
            idx   <= '0;
            an_q  <= 8'hFE;
            seg_q <= 8'b0000_0011;
        end else begin
            an_q  <= an_nxt;
            seg_q <= seg_nxt;
            if (pre == PRE_LAST) begin
                pre <= '0;
                idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
            end else begin
                pre <= pre + 1'b1;
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.An   = an_q;
    assign bus.Seg  = seg_q;

endmodule

// File: tb/tb_ssd_display_ctrl.sv
// Bench for ssd_display_ctrl: digit-level model of the display, checked every cycle on An/Seg/busy.
module tb_ssd_display_ctrl;
    localparam int DIV = 4;
    localparam int ND  = 8;
    localparam logic [6:0] SEGTAB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    logic ClkPort = 1'b0;
    logic Reset   = 1'b1;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   mdig   [8];
    bit   mblank [8];

    ssd_display_ctrl_if bus();

    ssd_display_ctrl #(.SCAN_DIV(DIV), .NUM_DIGITS(ND)) dut (
        .ClkPort (ClkPort),
        .Reset   (Reset),
        .bus     (bus)
    );

    always #5 ClkPort = ~ClkPort;

    // Edges seen since the last reset release.
    always @(posedge ClkPort or posedge Reset) begin
        if (Reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) begin
            mdig[i]   = 0;
            mblank[i] = 1'b0;
        end
    endfunction

    function automatic void model_set(input int v, input bit dec);
        int p;
        p = 1;
        for (int i = 0; i < 8; i++) begin
            if (dec) begin
                mdig[i]   = (i < 5) ? (v / p) % 10 : 0;
                mblank[i] = (i >= 5);
                p = p * 10;
            end else begin
                mdig[i]   = (i < 4) ? (v >> (4 * i)) & 15 : 0;
                mblank[i] = (i >= 4);
            end
        end
    endfunction

    // Digit being shown at the sample after edge n: the one selected during the previous cycle.
    function automatic int exp_idx(input int n);
        return (n == 0) ? 0 : ((n - 1) / DIV) % ND;
    endfunction

    function automatic logic [7:0] exp_an(input int n);
        return ~(8'b0000_0001 << exp_idx(n));
    endfunction

    function automatic logic [7:0] exp_seg(input int n);
        int idx;
        bit blank;
        bit allz;
        idx   = exp_idx(n);
        blank = mblank[idx];
        allz  = 1'b1;
        for (int j = idx; j < 8; j++) if (mdig[j] != 0) allz = 1'b0;
        if (bus.blank_lz && idx > 0 && allz) blank = 1'b1;
        return blank ? 8'hFF : {SEGTAB[mdig[idx]], ~bus.dp_mask[idx]};
    endfunction

    task automatic watch_load(input string name, input int v, input bit dec, input int ncyc);
        int  L, commit_edge, busy_last, n;
        bit  exp_b;
        @(negedge ClkPort);
        bus.value_in = 16'(v);
        bus.dec_mode = dec;
        bus.load     = 1'b1;
        L            = cyc + 1;
        commit_edge  = dec ? L + 17 : L;
        busy_last    = dec ? L + 16 : L - 1;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge ClkPort);
            bus.load = 1'b0;
            n = cyc;
            if (n - 1 == commit_edge) model_set(v, dec);
            exp_b = (n >= L) && (n <= busy_last);
            checks++;
            if (bus.busy !== exp_b) begin
                errors++;
                $display("FAIL %s busy cyc %0d got %b want %b", name, n - L, bus.busy, exp_b);
            end
            checks++;
            if (bus.An !== exp_an(n)) begin
                errors++;
                $display("FAIL %s An cyc %0d got %h want %h", name, n - L, bus.An, exp_an(n));
            end
            checks++;
            if (bus.Seg !== exp_seg(n)) begin
                errors++;
                $display("FAIL %s Seg cyc %0d got %b want %b", name, n - L, bus.Seg, exp_seg(n));
            end
        end
    endtask

    task automatic test_reset();
        int n;
        bus.value_in = '0;
        bus.load     = 1'b0;
        bus.dec_mode = 1'b0;
        bus.blank_lz = 1'b0;
        bus.dp_mask  = 8'($urandom);
        Reset        = 1'b1;
        repeat (3) @(negedge ClkPort);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", bus.busy); end
        checks++;
        if (bus.An !== 8'hFE) begin errors++; $display("FAIL reset An got %h want fe", bus.An); end
        checks++;
        if (bus.Seg !== 8'h03) begin errors++; $display("FAIL reset Seg got %h want 03", bus.Seg); end
        model_clear();
        Reset = 1'b0;
        for (int k = 0; k < 2 * ND * DIV + 4; k++) begin
            @(negedge ClkPort);
            n = cyc;
            checks++;
            if (bus.An !== exp_an(n)) begin
                errors++;
                $display("FAIL scan An cyc %0d got %h want %h", n, bus.An, exp_an(n));
            end
            checks++;
            if (bus.Seg !== exp_seg(n)) begin
                errors++;
                $display("FAIL scan Seg cyc %0d got %b want %b", n, bus.Seg, exp_seg(n));
            end
        end
    endtask

    task automatic test_hex();
        @(negedge ClkPort);
        bus.blank_lz = 1'b0;
        bus.dp_mask  = 8'h00;
        watch_load("hex_beef", 16'hBEEF, 1'b0, 40);
        @(negedge ClkPort);
        bus.blank_lz = 1'b1;
        bus.dp_mask  = 8'h0F;
        watch_load("hex_lz", 16'h00A0, 1'b0, 40);
    endtask

    task automatic test_dec_max();
        @(negedge ClkPort);
        bus.blank_lz = 1'b0;
        bus.dp_mask  = 8'h00;
        watch_load("dec_max", 65535, 1'b1, 52);
    endtask

    task automatic test_lz();
        @(negedge ClkPort);
        bus.blank_lz = 1'b1;
        bus.dp_mask  = 8'h00;
        watch_load("dec_42", 42, 1'b1, 52);
        watch_load("dec_zero", 0, 1'b1, 52);
    endtask

    task automatic test_back_to_back();
        int L, n;
        bit exp_b;
        @(negedge ClkPort);
        bus.blank_lz = 1'b1;
        bus.dp_mask  = 8'($urandom);
        @(negedge ClkPort);
        bus.value_in = 16'd100;
        bus.dec_mode = 1'b1;
        bus.load     = 1'b1;
        L = cyc + 1;
        for (int k = 0; k < 72; k++) begin
            @(negedge ClkPort);
            bus.load = 1'b0;
            n = cyc;
            if (n - 1 == L + 17) model_set(100, 1'b1);
            if (n - 1 == L + 34) model_set(9, 1'b1);
            exp_b = (n >= L) && (n <= L + 33);
            checks++;
            if (bus.busy !== exp_b) begin
                errors++;
                $display("FAIL b2b busy cyc %0d got %b want %b", n - L, bus.busy, exp_b);
            end
            checks++;
            if (bus.An !== exp_an(n)) begin
                errors++;
                $display("FAIL b2b An cyc %0d got %h want %h", n - L, bus.An, exp_an(n));
            end
            checks++;
            if (bus.Seg !== exp_seg(n)) begin
                errors++;
                $display("FAIL b2b Seg cyc %0d got %b want %b", n - L, bus.Seg, exp_seg(n));
            end
            if (n == L + 4) begin bus.value_in = 16'd7; bus.dec_mode = 1'b1; bus.load = 1'b1; end
            if (n == L + 7) begin bus.value_in = 16'd9; bus.dec_mode = 1'b1; bus.load = 1'b1; end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge ClkPort);
        bus.blank_lz = 1'b0;
        bus.dp_mask  = 8'h00;
        @(negedge ClkPort);
        bus.value_in = 16'd500;
        bus.dec_mode = 1'b1;
        bus.load     = 1'b1;
        @(negedge ClkPort);
        bus.load = 1'b0;
        repeat (10) @(negedge ClkPort);
        Reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset busy got %b want 0", bus.busy); end
        checks++;
        if (bus.An !== 8'hFE) begin errors++; $display("FAIL midreset An got %h want fe", bus.An); end
        checks++;
        if (bus.Seg !== 8'h03) begin errors++; $display("FAIL midreset Seg got %h want 03", bus.Seg); end
        model_clear();
        @(negedge ClkPort);
        Reset = 1'b0;
        watch_load("dec_after_reset", 123, 1'b1, 52);
    endtask

    task automatic test_random();
        int v;
        bit d;
        for (int t = 0; t < 6; t++) begin
            @(negedge ClkPort);
            bus.blank_lz = 1'($urandom_range(0, 1));
            bus.dp_mask  = 8'($urandom);
            v = int'($urandom_range(0, 65535));
            d = 1'($urandom_range(0, 1));
            watch_load("random", v, d, 52);
        end
    endtask

    initial begin
        test_reset();
        test_hex();
        test_dec_max();
        test_lz();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
